// File: rtl/mac_if_pkg.sv
// Shared RX MAC types: frame-control FSM states, RX error codes and the per-frame status record.
package mac_if_pkg;

  localparam int unsigned LEN_W = 16;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_ctrl_state_t;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_CRC     = 3'd1,
    ERR_RUNT    = 3'd2,
    ERR_GIANT   = 3'd3,
    ERR_GMII_ER = 3'd4,
    ERR_NO_SFD  = 3'd5,
    ERR_OVERRUN = 3'd6
  } rx_err_code_t;

  typedef struct packed {
    logic             good;
    rx_err_code_t     err;
    logic [LEN_W-1:0] len;
  } rx_status_t;

endpackage

// File: rtl/rx_frame_ctrl_skid.sv
// One-entry valid/ready holding register for the per-frame status record.
module rx_status_skid
  import mac_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  rx_status_t i_data,
  output logic       o_ready,
  output logic       o_valid,
  output rx_status_t o_data,
  input  logic       i_ready
);

  logic       r_valid;
  rx_status_t r_data;

  // A new record may load in the same cycle the held one is accepted.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Per-frame RX sequencer: preamble/SFD hunt, CRC checker gating, byte count and status record.
// Optional statistics counters are built when RX_FRAME_CTRL_STATS_EN is defined.
module rx_frame_ctrl
  import mac_if_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned MAX_PREAMBLE  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gmii_valid_i,
  input  logic             gmii_er_i,
  input  logic [7:0]       gmii_data_i,
  input  logic             crc_ok_i,
  output logic             crc_clr_o,
  output logic             crc_en_o,
  output logic             status_valid_o,
  input  logic             status_ready_i,
  output logic             status_good_o,
  output logic [2:0]       status_err_o,
  output logic [LEN_W-1:0] status_len_o
`ifdef RX_FRAME_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_good_o,
  output logic [31:0]      stat_bad_o,
  output logic [31:0]      stat_ovr_o
`endif
);

  localparam int unsigned PRE_W = 4;

  rx_ctrl_state_t   r_state;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_er;
  logic             r_fin_v;
  rx_status_t       r_fin;
  logic             r_ovr;

  rx_err_code_t     w_end_err;
  rx_status_t       w_rec;
  rx_status_t       w_out;
  logic             w_skid_rdy;

  // CRC strobes align with the byte on gmii_data_i, so they decode the live input.
  assign crc_clr_o = !rst && gmii_valid_i && (gmii_data_i == SFD_BYTE) &&
                     ((r_state == ST_IDLE) || (r_state == ST_PREAMBLE));
  assign crc_en_o  = !rst && gmii_valid_i && (r_state == ST_DATA);

  always_comb begin
    w_end_err = ERR_OK;
    if (r_er)                                 w_end_err = ERR_GMII_ER;
    else if (r_len < LEN_W'(MIN_FRAME_LEN))   w_end_err = ERR_RUNT;
    else if (r_len > LEN_W'(MAX_FRAME_LEN))   w_end_err = ERR_GIANT;
    else if (!crc_ok_i)                       w_end_err = ERR_CRC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= '0;
      r_len     <= '0;
      r_er      <= 1'b0;
      r_fin_v   <= 1'b0;
      r_fin     <= '0;
    end else begin
      r_fin_v <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_pre_cnt <= '0;
          r_len     <= '0;
          r_er      <= 1'b0;
          if (gmii_valid_i) begin
            if (gmii_data_i == PREAMBLE_BYTE) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= PRE_W'(1);
            end else if (gmii_data_i == SFD_BYTE) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_valid_i) begin
            r_state <= ST_IDLE;
          end else begin
            if (gmii_er_i) r_er <= 1'b1;
            if (gmii_data_i == PREAMBLE_BYTE) begin
              if (r_pre_cnt >= PRE_W'(MAX_PREAMBLE)) r_state <= ST_DROP;
              else r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end else if (gmii_data_i == SFD_BYTE) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_DATA: begin
          if (gmii_valid_i) begin
            if (r_len != '1) r_len <= r_len + LEN_W'(1);
            if (gmii_er_i)   r_er  <= 1'b1;
          end else begin
            r_fin_v <= 1'b1;
            r_fin   <= '{good: (w_end_err == ERR_OK), err: w_end_err, len: r_len};
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!gmii_valid_i) begin
            r_fin_v <= 1'b1;
            r_fin   <= '{good: 1'b0, err: ERR_NO_SFD, len: r_len};
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun: set when a finished record finds the holding register busy, cleared on load.
  assign w_rec = r_ovr ? '{good: 1'b0, err: ERR_OVERRUN, len: r_fin.len} : r_fin;

  always_ff @(posedge clk) begin
    if (rst)          r_ovr <= 1'b0;
    else if (r_fin_v) r_ovr <= !w_skid_rdy;
  end

  rx_status_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_fin_v),
    .i_data  (w_rec),
    .o_ready (w_skid_rdy),
    .o_valid (status_valid_o),
    .o_data  (w_out),
    .i_ready (status_ready_i)
  );

  assign status_good_o = w_out.good;
  assign status_err_o  = w_out.err;
  assign status_len_o  = w_out.len;

`ifdef RX_FRAME_CTRL_STATS_EN
  logic [31:0] r_stat_good;
  logic [31:0] r_stat_bad;
  logic [31:0] r_stat_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_good <= '0;
      r_stat_bad  <= '0;
      r_stat_ovr  <= '0;
    end else if (r_fin_v) begin
      if (!w_skid_rdy)   r_stat_ovr  <= r_stat_ovr + 32'd1;
      else if (w_rec.good) r_stat_good <= r_stat_good + 32'd1;
      else                 r_stat_bad  <= r_stat_bad + 32'd1;
    end
  end

  assign stat_good_o = r_stat_good;
  assign stat_bad_o  = r_stat_bad;
  assign stat_ovr_o  = r_stat_ovr;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl with a behavioural CRC-32 checker and expected-record queue.
`timescale 1ns/1ps
module tb_rx_frame_ctrl;
  import mac_if_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             gmii_valid_i = 1'b0;
  logic             gmii_er_i = 1'b0;
  logic [7:0]       gmii_data_i = 8'h00;
  logic             crc_ok_i;
  logic             crc_clr_o;
  logic             crc_en_o;
  logic             status_valid_o;
  logic             status_ready_i = 1'b1;
  logic             status_good_o;
  logic [2:0]       status_err_o;
  logic [LEN_W-1:0] status_len_o;

  always #4 clk = ~clk;

  rx_frame_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .gmii_valid_i   (gmii_valid_i),
    .gmii_er_i      (gmii_er_i),
    .gmii_data_i    (gmii_data_i),
    .crc_ok_i       (crc_ok_i),
    .crc_clr_o      (crc_clr_o),
    .crc_en_o       (crc_en_o),
    .status_valid_o (status_valid_o),
    .status_ready_i (status_ready_i),
    .status_good_o  (status_good_o),
    .status_err_o   (status_err_o),
    .status_len_o   (status_len_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int end_cyc = -100;
  int n_clr  = 0;
  int n_rec  = 0;
  logic seen_clr = 1'b0;
  rx_status_t exp_q[$];
  logic [7:0] fb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  // Registered CRC checker model: crc_ok reflects bytes consumed up to the previous edge.
  logic [31:0] r_crc = 32'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crc_clr_o)     r_crc <= 32'hFFFFFFFF;
    else if (crc_en_o) r_crc <= crc_upd(r_crc, gmii_data_i);
  end
  assign crc_ok_i = (r_crc == 32'hDEBB20E3);

  // Build preamble, optional SFD, then n_frame bytes whose last four are the FCS.
  task automatic build(input int n_pre, input bit sfd, input int n_frame, input bit flip);
    logic [31:0] c;
    logic [7:0]  b;
    fb.delete();
    for (int i = 0; i < n_pre; i++) fb.push_back(PREAMBLE_BYTE);
    if (sfd) fb.push_back(SFD_BYTE);
    if (n_frame >= 4) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n_frame - 4; i++) begin
        b = 8'(i * 7 + 3);
        fb.push_back(b);
        c = crc_upd(c, b);
      end
      c = ~c;
      fb.push_back(c[7:0]);
      fb.push_back(c[15:8]);
      fb.push_back(c[23:16]);
      fb.push_back(c[31:24]);
      if (flip) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
    end
  endtask

  // Drive fb; the cycle after the last byte (valid low) is the frame-end cycle.
  task automatic drive(input int er_idx);
    for (int i = 0; i < fb.size(); i++) begin
      @(posedge clk); #1;
      gmii_valid_i = 1'b1;
      gmii_data_i  = fb[i];
      gmii_er_i    = (i == er_idx);
    end
    @(posedge clk); #1;
    gmii_valid_i = 1'b0;
    gmii_er_i    = 1'b0;
    gmii_data_i  = 8'h00;
    end_cyc      = cyc;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    while ((exp_q.size() != 0 || status_valid_o) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic push(input logic good, input rx_err_code_t err, input int len);
    rx_status_t r;
    r.good = good;
    r.err  = err;
    r.len  = LEN_W'(len);
    exp_q.push_back(r);
  endtask

  // Compare process: latency of each new record, stability while held, content on accept.
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  int         p_rec = 0;
  rx_status_t e;
  always @(negedge clk) begin
    if (rst) begin
      p_valid  = 1'b0;
      seen_clr = 1'b0;
    end else begin
      if (crc_clr_o) begin
        n_clr++;
        seen_clr = 1'b1;
      end
      if (crc_en_o && !seen_clr) chk("clr_before_en", 0, 1);
      if (!gmii_valid_i) seen_clr = 1'b0;
      if (status_valid_o) begin
        if (p_valid && !p_ready)
          chk("hold_stable", int'({status_good_o, status_err_o, status_len_o}), p_rec);
        else
          chk("latency", cyc - end_cyc, 2);
        if (status_ready_i) begin
          n_rec++;
          if (exp_q.size() == 0) begin
            chk("unexpected_record", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("good", int'(status_good_o), int'(e.good));
            chk("err", int'(status_err_o), int'(e.err));
            chk("len", int'(status_len_o), int'(e.len));
          end
        end
      end
      p_valid = status_valid_o;
      p_ready = status_ready_i;
      p_rec   = int'({status_good_o, status_err_o, status_len_o});
    end
  end

  initial begin
    int snap;
    logic [31:0] c;
    logic [7:0]  s9 [9];

    // Pin the CRC model against the standard check value.
    for (int i = 0; i < 9; i++) s9[i] = 8'h31 + 8'(i);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_upd(c, s9[i]);
    chk("crc_model_check_value", int'(~c), int'(32'hCBF43926));

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(status_valid_o), 0);
    chk("rst_good", int'(status_good_o), 0);
    chk("rst_err", int'(status_err_o), 0);
    chk("rst_len", int'(status_len_o), 0);
    chk("rst_crc_clr", int'(crc_clr_o), 0);
    chk("rst_crc_en", int'(crc_en_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Good 64-byte frame.
    n_clr = 0;
    build(7, 1, 64, 0); push(1'b1, ERR_OK, 64); drive(-1); drain("good64");
    chk("good64_clr_pulses", n_clr, 1);

    // Corrupted FCS.
    n_clr = 0;
    build(7, 1, 64, 1); push(1'b0, ERR_CRC, 64); drive(-1); drain("crc64");
    chk("crc64_clr_pulses", n_clr, 1);

    // Runt and giant.
    build(7, 1, 60, 0); push(1'b0, ERR_RUNT, 60); drive(-1); drain("runt60");
    build(7, 1, 1519, 0); push(1'b0, ERR_GIANT, 1519); drive(-1); drain("giant1519");
    build(7, 1, 1518, 0); push(1'b1, ERR_OK, 1518); drive(-1); drain("max1518");

    // Too long a preamble.
    build(9, 1, 0, 0); push(1'b0, ERR_NO_SFD, 0); drive(-1); drain("no_sfd");

    // GMII error on frame byte 20.
    build(7, 1, 64, 0); push(1'b0, ERR_GMII_ER, 64); drive(8 + 20); drain("gmii_er");

    // Back-to-back with one idle cycle, consumer ready.
    build(7, 1, 64, 0); push(1'b1, ERR_OK, 64); push(1'b1, ERR_OK, 64);
    drive(-1); drive(-1); drain("b2b");

    // Consumer stalls: first record held, second dropped, third reports overrun.
    status_ready_i = 1'b0;
    push(1'b1, ERR_OK, 64);
    drive(-1); drive(-1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("held_valid", int'(status_valid_o), 1);
    chk("held_len", int'(status_len_o), 64);
    @(posedge clk); #1;
    status_ready_i = 1'b1;
    drain("held_accept");
    push(1'b0, ERR_OVERRUN, 64); drive(-1); drain("overrun");
    push(1'b1, ERR_OK, 64); drive(-1); drain("after_overrun");

    // Carrier glitch: one preamble byte then idle.
    snap = n_rec;
    build(1, 0, 0, 0); drive(-1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch_no_record", n_rec - snap, 0);
    chk("glitch_valid", int'(status_valid_o), 0);

    // Reset at frame byte 30.
    snap = n_rec;
    build(7, 1, 64, 0);
    for (int i = 0; i < 8 + 30; i++) begin
      @(posedge clk); #1;
      gmii_valid_i = 1'b1;
      gmii_data_i  = fb[i];
    end
    @(posedge clk); #1;
    rst = 1'b1;
    gmii_valid_i = 1'b0;
    gmii_data_i  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", int'(status_valid_o), 0);
    chk("midrst_len", int'(status_len_o), 0);
    chk("midrst_crc_en", int'(crc_en_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_record", n_rec - snap, 0);
    build(7, 1, 64, 0); push(1'b1, ERR_OK, 64); drive(-1); drain("post_rst_good");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
